// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter feeding a UART TX through an AXI-Lite master.
// Polls the status register until TX is not full, then writes the granted byte exactly once.
module uart_tx_arbiter #(
   parameter int unsigned POLL_GAP = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [7:0]  req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_data,
   output logic        req1_ready,
   output logic [15:0] m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [15:0] m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic        busy,
   output logic        grant_id,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      POLL_AR,
      POLL_R,
      GAP,
      WR,
      WR_B
   } state_t;

   localparam logic [15:0] STATUS_ADDR = 16'h0008;
   localparam logic [15:0] TXDATA_ADDR = 16'h0004;
   localparam logic [8:0]  GAP_LEN     = 9'(POLL_GAP);

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_id_q, grant_id_d;
   logic [7:0]  byte_q, byte_d;
   logic        err_q, err_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   logic        grant_sel;
   logic        accept;
   logic        aw_hs;
   logic        w_hs;
   logic        gap_last;
   logic        unused_rdata;

   // Round-robin: a lone requester always wins, a tie goes to whoever did not win last.
   always_comb begin
      grant_sel = ~last_grant_q;
      if (req0_valid && !req1_valid) begin
         grant_sel = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant_sel = 1'b1;
      end
   end

   assign req0_ready = (state_q == IDLE) && !grant_sel;
   assign req1_ready = (state_q == IDLE) &&  grant_sel;
   assign accept     = (state_q == IDLE) && (grant_sel ? req1_valid : req0_valid);

   // All AXI valid/ready outputs decode registered state only.
   assign m_axi_araddr  = STATUS_ADDR;
   assign m_axi_arvalid = (state_q == POLL_AR);
   assign m_axi_rready  = (state_q == POLL_R);
   assign m_axi_awaddr  = TXDATA_ADDR;
   assign m_axi_wdata   = {23'b0, 1'b0, byte_q};
   assign m_axi_awvalid = (state_q == WR) && !aw_done_q;
   assign m_axi_wvalid  = (state_q == WR) && !w_done_q;
   assign m_axi_bready  = (state_q == WR_B);

   assign aw_hs    = m_axi_awvalid && m_axi_awready;
   assign w_hs     = m_axi_wvalid && m_axi_wready;
   assign gap_last = ({1'b0, gap_cnt_q} + 9'd1) >= GAP_LEN;

   assign busy     = (state_q != IDLE);
   assign grant_id = grant_id_q;
   assign err      = err_q;

   // Only the tx_full flag of the status word matters.
   assign unused_rdata = ^{m_axi_rdata[31:4], m_axi_rdata[2:0]};

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      byte_d       = byte_q;
      err_d        = err_q;
      gap_cnt_d    = gap_cnt_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               byte_d       = grant_sel ? req1_data : req0_data;
               grant_id_d   = grant_sel;
               last_grant_d = grant_sel;
               state_d      = POLL_AR;
            end
         end
         POLL_AR: begin
            if (m_axi_arready) begin
               state_d = POLL_R;
            end
         end
         POLL_R: begin
            if (m_axi_rvalid) begin
               if (m_axi_rresp != 2'b00) begin
                  err_d = 1'b1;
               end
               if (m_axi_rdata[3] || (m_axi_rresp != 2'b00)) begin
                  gap_cnt_d = 8'd0;
                  state_d   = GAP;
               end else begin
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = WR;
               end
            end
         end
         GAP: begin
            if (gap_last) begin
               state_d = POLL_AR;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         WR: begin
            if (aw_hs) begin
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d = WR_B;
            end
         end
         WR_B: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != 2'b00) begin
                  err_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         err_q        <= 1'b0;
         gap_cnt_q    <= 8'd0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         err_q        <= err_d;
         gap_cnt_q    <= gap_cnt_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
      end
   end

   always_ff @(posedge clock) begin
      byte_q <= byte_d;
   end

endmodule
